imem_loader: RTL and testbench

Boot-time program loader for the single-cycle RISC-V core: accepts a framed byte stream over a valid/ready handshake, packs bytes into little-endian 32-bit instructions and writes them into instruction memory. It is the writer side of the instruction memory that the fetch stage reads. It holds the core in reset until a complete, checksum-verified program is in memory.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_if.sv | 20 ++
 rtl/imem_loader_packer.sv | 34 +++
 rtl/imem_loader.sv | 150 +++++++++++++++
 tb/tb_imem_loader.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared states, error codes and framing constants for the program loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write port bundles
interface byte_stream_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

interface imem_wr_if #(
  parameter int ADDR_W = 8
);
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (output imem_we, output imem_addr, output imem_wdata);
  modport slave  (input imem_we, input imem_addr, input imem_wdata);
endinterface

// File: rtl/imem_loader_packer.sv
// rtl/imem_loader_packer.sv - assembles little-endian 32-bit words from accepted bytes
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  cnt_q;
  logic [31:0] sh_q;

  // Bytes enter at the top and shift down, so after four bytes the first one sits in [7:0].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 2'd0;
      sh_q  <= 32'd0;
    end else if (clear_i) begin
      cnt_q <= 2'd0;
      sh_q  <= 32'd0;
    end else if (byte_en_i) begin
      cnt_q <= cnt_q + 2'd1;
      sh_q  <= {byte_i, sh_q[31:8]};
    end
  end

  assign word_o       = {byte_i, sh_q[31:8]};
  assign word_valid_o = byte_en_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed boot loader writing verified programs into instruction memory
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  byte_stream_if.slave   in_s,
  imem_wr_if.master      wr_m,
  output logic           core_hold_o,
  output logic           done_o,
  output logic           err_o,
  output logic [1:0]     err_code_o
);

  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

  state_e            state_q;
  logic [15:0]       word_cnt_q;
  logic [15:0]       len_q;
  logic [7:0]        len_lo_q;
  logic [7:0]        csum_q;
  logic              in_ready_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic              core_hold_q;
  logic              done_q;
  logic              err_q;
  logic [1:0]        err_code_q;

  logic        accept;
  logic        load_start;
  logic [15:0] len_rx;
  logic [15:0] word_cnt_nxt;
  logic [31:0] word;
  logic        word_valid;

  assign accept       = in_s.in_valid && in_ready_q;
  assign load_start   = start_i && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign len_rx       = {in_s.in_data, len_lo_q};
  assign word_cnt_nxt = word_cnt_q + 16'd1;

  byte_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (load_start),
    .byte_en_i    (accept && (state_q == ST_DATA)),
    .byte_i       (in_s.in_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      word_cnt_q   <= 16'd0;
      len_q        <= 16'd0;
      len_lo_q     <= 8'd0;
      csum_q       <= 8'd0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      core_hold_q  <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_i) begin
            state_q     <= ST_LEN0;
            word_cnt_q  <= 16'd0;
            csum_q      <= 8'd0;
            in_ready_q  <= 1'b1;
            core_hold_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
          end
        end
        ST_LEN0: begin
          if (accept) begin
            len_lo_q <= in_s.in_data;
            state_q  <= ST_LEN1;
          end
        end
        ST_LEN1: begin
          if (accept) begin
            len_q <= len_rx;
            if ({1'b0, len_rx} > CAPACITY) begin
              state_q    <= ST_ERR;
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
              err_code_q <= ERR_LEN;
            end else if (len_rx == 16'd0) begin
              state_q <= ST_CSUM;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept) begin
            csum_q <= csum_q ^ in_s.in_data;
            if (word_valid) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= word_cnt_q[ADDR_W-1:0];
              imem_wdata_q <= word;
              word_cnt_q   <= word_cnt_nxt;
              if (word_cnt_nxt == len_q) state_q <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (in_s.in_data == csum_q) begin
              state_q     <= ST_DONE;
              done_q      <= 1'b1;
              core_hold_q <= 1'b0;
            end else begin
              state_q    <= ST_ERR;
              err_q      <= 1'b1;
              err_code_q <= ERR_CSUM;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_s.in_ready   = in_ready_q;
  assign wr_m.imem_we    = imem_we_q;
  assign wr_m.imem_addr  = imem_addr_q;
  assign wr_m.imem_wdata = imem_wdata_q;
  assign core_hold_o     = core_hold_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign err_code_o      = err_code_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

  localparam int AW  = 8;
  localparam int CAP = 1 << AW;

  typedef struct packed {
    logic [3:0]  nb;
    logic [87:0] bytes;
    logic        exp_done;
    logic [1:0]  exp_code;
    logic [2:0]  exp_nw;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       core_hold, done, err;
  logic [1:0] err_code;

  byte_stream_if bs ();
  imem_wr_if #(.ADDR_W(AW)) wr ();

  imem_loader #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .in_s        (bs),
    .wr_m        (wr),
    .core_hold_o (core_hold),
    .done_o      (done),
    .err_o       (err),
    .err_code_o  (err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int test_id = 0;

  logic [7:0]  frame_q[$];
  logic [31:0] exp_w[$];
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  vec_t        vecs[6];
  logic        m_done;
  logic [1:0]  m_code;

  always @(negedge clk) begin
    if (wr.imem_we === 1'b1) begin
      wr_addr.push_back(wr.imem_addr);
      wr_data.push_back(wr.imem_wdata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL test=%0d %s actual=%h required=%h", test_id, name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called and returns on a falling edge; in_ready is registered, so a high value seen
  // here guarantees acceptance at the following rising edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap, output bit ok);
    int cyc;
    ok = 1'b0;
    bs.in_valid = 1'b0;
    repeat ($urandom_range(0, max_gap)) begin
      bs.in_data = 8'($urandom);
      @(negedge clk);
    end
    bs.in_data  = b;
    bs.in_valid = 1'b1;
    cyc = 0;
    while (cyc < 50 && !ok) begin
      if (bs.in_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
      cyc++;
    end
    bs.in_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input int max_gap);
    bit ok;
    for (int i = lo; i <= hi; i++) begin
      send_byte(frame_q[i], max_gap, ok);
      if (!ok) begin
        chk("byte_accept_timeout", 32'(i), 32'hFFFF_FFFF);
        return;
      end
    end
  endtask

  task automatic wait_status();
    int k = 0;
    while (k < 30 && !(done === 1'b1 || err === 1'b1)) begin
      @(negedge clk);
      k++;
    end
    if (!(done === 1'b1 || err === 1'b1)) chk("status_timeout", 32'd0, 32'd1);
  endtask

  task automatic begin_frame();
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    chk("ready_after_start", 32'(bs.in_ready), 32'd1);
    chk("done_cleared", 32'(done), 32'd0);
    chk("err_cleared", 32'(err), 32'd0);
    chk("hold_after_start", 32'(core_hold), 32'd1);
  endtask

  task automatic run_frame(input int max_gap);
    begin_frame();
    send_range(0, frame_q.size() - 1, max_gap);
    wait_status();
  endtask

  task automatic check_result(input logic exp_done, input logic [1:0] exp_code);
    int n;
    chk("done", 32'(done), 32'(exp_done));
    chk("err", 32'(err), 32'(exp_code != 2'd0));
    chk("err_code", 32'(err_code), 32'(exp_code));
    chk("core_hold", 32'(core_hold), 32'(!exp_done));
    chk("in_ready_end", 32'(bs.in_ready), 32'd0);
    chk("write_count", 32'(wr_addr.size()), 32'(exp_w.size()));
    n = (wr_addr.size() < exp_w.size()) ? wr_addr.size() : exp_w.size();
    for (int i = 0; i < n; i++) begin
      chk("write_addr", 32'(wr_addr[i]), 32'(i));
      chk("write_data", wr_data[i], exp_w[i]);
    end
  endtask

  // Reference: interpret the frame from its byte-level rules.
  task automatic model();
    int n;
    logic [7:0] x;
    exp_w.delete();
    n = int'(frame_q[0]) + 256 * int'(frame_q[1]);
    if (n > CAP) begin
      m_done = 1'b0;
      m_code = 2'd1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      logic [31:0] w = 32'd0;
      for (int j = 0; j < 4; j++) begin
        w = w + (32'(frame_q[2 + 4 * i + j]) << (8 * j));
        x = x ^ frame_q[2 + 4 * i + j];
      end
      exp_w.push_back(w);
    end
    m_done = (frame_q[2 + 4 * n] == x);
    m_code = m_done ? 2'd0 : 2'd2;
  endtask

  task automatic build_random(input int n, input bit corrupt);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(8'(n));
    frame_q.push_back(8'(n >> 8));
    if (n <= CAP) begin
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        x = x ^ b;
        frame_q.push_back(b);
      end
      frame_q.push_back(corrupt ? (x ^ 8'($urandom_range(1, 255))) : x);
    end
  endtask

  task automatic load_vec(input int t);
    frame_q.delete();
    for (int i = 0; i < int'(vecs[t].nb); i++) frame_q.push_back(vecs[t].bytes[8 * i +: 8]);
    exp_w.delete();
    if (vecs[t].exp_nw >= 3'd1) exp_w.push_back(vecs[t].w0);
    if (vecs[t].exp_nw >= 3'd2) exp_w.push_back(vecs[t].w1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, 32'(bs.in_ready), 32'd0);
    chk({tag, "_imem_we"}, 32'(wr.imem_we), 32'd0);
    chk({tag, "_imem_addr"}, 32'(wr.imem_addr), 32'd0);
    chk({tag, "_imem_wdata"}, wr.imem_wdata, 32'd0);
    chk({tag, "_core_hold"}, 32'(core_hold), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_err_code"}, 32'(err_code), 32'd0);
  endtask

  initial begin
    // Checksum is the XOR of the data bytes: 13^05^A0^00^B3^05^B5^00 = B5.
    vecs[0] = '{4'd11, 88'hB5_00_B5_05_B3_00_A0_05_13_00_02, 1'b1, 2'd0, 3'd2, 32'h00A00513, 32'h00B505B3};
    vecs[1] = '{4'd11, 88'h00_00_B5_05_B3_00_A0_05_13_00_02, 1'b0, 2'd2, 3'd2, 32'h00A00513, 32'h00B505B3};
    vecs[2] = '{4'd2,  88'h01_01,                            1'b0, 2'd1, 3'd0, 32'h0, 32'h0};
    vecs[3] = '{4'd3,  88'h00_00_00,                         1'b1, 2'd0, 3'd0, 32'h0, 32'h0};
    vecs[4] = '{4'd7,  88'h22_DE_AD_BE_EF_00_01,             1'b1, 2'd0, 3'd1, 32'hDEADBEEF, 32'h0};
    vecs[5] = '{4'd3,  88'h5A_00_00,                         1'b0, 2'd2, 3'd0, 32'h0, 32'h0};

    bs.in_data  = 8'h00;
    bs.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    test_id = 1;
    check_reset_values("reset");
    bs.in_data  = 8'hA5;
    bs.in_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_in_ready", 32'(bs.in_ready), 32'd0);
    chk("idle_no_write", 32'(wr_addr.size()), 32'd0);
    bs.in_valid = 1'b0;

    for (int t = 0; t < 6; t++) begin
      test_id = 10 + t;
      load_vec(t);
      run_frame(0);
      check_result(vecs[t].exp_done, vecs[t].exp_code);
    end

    test_id = 20;
    load_vec(0);
    run_frame(3);
    check_result(1'b1, 2'd0);

    test_id = 21;
    load_vec(0);
    begin_frame();
    send_range(0, 5, 1);
    pulse_start();
    chk("start_ignored_ready", 32'(bs.in_ready), 32'd1);
    chk("start_ignored_hold", 32'(core_hold), 32'd1);
    send_range(6, 10, 1);
    wait_status();
    check_result(1'b1, 2'd0);

    test_id = 22;
    load_vec(0);
    begin_frame();
    send_range(0, 6, 0);
    rst = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("postreset");
    run_frame(0);
    check_result(1'b1, 2'd0);

    test_id = 23;
    build_random(CAP, 1'b0);
    model();
    run_frame(0);
    check_result(m_done, m_code);

    for (int it = 0; it < 40; it++) begin
      int n;
      test_id = 100 + it;
      n = ($urandom_range(0, 9) == 9) ? (CAP + 1 + int'($urandom_range(0, 65535 - CAP - 1)))
                                        : int'($urandom_range(0, 6));
      build_random(n, $urandom_range(0, 3) == 0);
      model();
      run_frame(int'($urandom_range(0, 3)));
      check_result(m_done, m_code);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
